// File: rtl/load_unit.sv
// Load path from data memory to rd_mux: word-aligned read handshake, then
// byte/half/word extraction with sign or zero extension.
module load_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_req,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [2:0]      ld_funct3,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] rd_mem,
  output logic            ld_done,
  output logic            ld_err,
  output logic            stall
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  // Timeout fires on the REQ cycle whose count would reach TIMEOUT.
  localparam bit               TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] rd_mem_q, rd_mem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            check_err;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;

  always_comb begin
    unique case (ld_funct3)
      F_LB, F_LBU: check_err = 1'b0;
      F_LH, F_LHU: check_err = ld_addr[0];
      F_LW:        check_err = (ld_addr[1:0] != 2'b00);
      default:     check_err = 1'b1;
    endcase
  end

  assign byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    unique case (funct3_q)
      F_LB:    load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F_LBU:   load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F_LH:    load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F_LHU:   load_data = {{(XLEN-16){1'b0}}, half_sel};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    rd_mem_d = rd_mem_q;
    cnt_d    = '0;

    unique case (state_q)
      S_IDLE: begin
        if (ld_req) begin
          addr_d   = ld_addr;
          funct3_d = ld_funct3;
          state_d  = check_err ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          rd_mem_d = load_data;
          state_d  = S_DONE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      rd_mem_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      rd_mem_q <= rd_mem_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mem_req  = (state_q == S_REQ);
  assign mem_addr = {addr_q[XLEN-1:2], 2'b00};
  assign rd_mem   = rd_mem_q;
  assign ld_done  = (state_q == S_DONE);
  assign ld_err   = (state_q == S_ERR);
  assign stall    = (state_q == S_REQ) ||
                    ((state_q == S_IDLE) && ld_req && !check_err);

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: directed cases plus random loads checked
// against a plain-arithmetic reference model.
module tb_load_unit;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            ld_req;
  logic [XLEN-1:0] ld_addr;
  logic [2:0]      ld_funct3;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] rd_mem;
  logic            ld_done;
  logic            ld_err;
  logic            stall;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit          stall;
    bit          req;
    bit          done;
    bit          err;
    logic [31:0] maddr;
  } cyc_t;

  resp_t       rsp_q[$];
  cyc_t        cyc_q[$];
  logic [31:0] model_rd = '0;

  load_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_req    (ld_req),
    .ld_addr   (ld_addr),
    .ld_funct3 (ld_funct3),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .rd_mem    (rd_mem),
    .ld_done   (ld_done),
    .ld_err    (ld_err),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_legal(input logic [31:0] addr, input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (addr % 2) == 0;
      3'd2:       return (addr % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3,
                                             input logic [31:0] w);
    int unsigned sh_b;
    int unsigned sh_h;
    logic [31:0] b;
    logic [31:0] h;
    sh_b = (addr % 4) * 8;
    sh_h = ((addr % 4) / 2) * 16;
    b = (w >> sh_b) & 32'hFF;
    h = (w >> sh_h) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256     : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'h1_0000  : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Issue one load, ack it in REQ cycle ack_k (cycle 0 is the issue cycle).
  // Caller must be positioned #1 after a rising edge.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] rdata, input int ack_k);
    bit   legal;
    bit   ok;
    int   n;
    int   len;
    cyc_t c;
    legal = model_legal(addr, f3);
    ok    = legal && (ack_k <= TIMEOUT);
    n     = legal ? ((ack_k <= TIMEOUT) ? ack_k : TIMEOUT) : 0;
    len   = ((n + 2) > (ack_k + 1) ? (n + 2) : (ack_k + 1)) + 1;
    for (int i = 0; i < len; i++) begin
      c.stall = legal && (i <= n);
      c.req   = legal && (i >= 1) && (i <= n);
      c.done  = ok && (i == n + 1);
      c.err   = !ok && (i == n + 1);
      c.maddr = addr & ~32'h3;
      cyc_q.push_back(c);
    end
    if (ok) begin
      model_rd = model_load(addr, f3, rdata);
      rsp_q.push_back('{is_err: 1'b0, data: model_rd});
    end else begin
      rsp_q.push_back('{is_err: 1'b1, data: model_rd});
    end
    for (int i = 0; i < len; i++) begin
      ld_req    = (i == 0);
      ld_addr   = (i == 0) ? addr : $urandom;
      ld_funct3 = (i == 0) ? f3 : 3'($urandom);
      mem_ack   = (i == ack_k);
      mem_rdata = (i == ack_k) ? rdata : $urandom;
      @(posedge clk);
      #1;
    end
    ld_req  = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Monitor: per-cycle protocol expectations and the response scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (cyc_q.size() > 0) begin
        cyc_t c;
        c = cyc_q.pop_front();
        check("stall", 32'(stall), 32'(c.stall));
        check("mem_req", 32'(mem_req), 32'(c.req));
        check("ld_done", 32'(ld_done), 32'(c.done));
        check("ld_err", 32'(ld_err), 32'(c.err));
        if (c.req) check("mem_addr", mem_addr, c.maddr);
      end
      if (ld_done || ld_err) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_resp", {30'd0, ld_done, ld_err}, 32'd0);
        end else begin
          resp_t r;
          r = rsp_q.pop_front();
          check("resp_kind_err", 32'(ld_err), 32'(r.is_err));
          check("rd_mem", rd_mem, r.data);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    ld_req    = 1'b0;
    ld_addr   = '0;
    ld_funct3 = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    #3;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rd_mem", rd_mem, 32'd0);
    check("rst_flags", {29'd0, ld_done, ld_err, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    run_load(32'h0000_1003, 3'b000, 32'h80AB_CDEF, 1);
    run_load(32'h0000_2002, 3'b101, 32'h9234_5678, 4);
    run_load(32'h0000_2002, 3'b001, 32'h9234_5678, 4);
    run_load(32'h0000_0006, 3'b010, 32'h1111_2222, 2);
    run_load(32'h0000_0006, 3'b011, 32'h3333_4444, 1);
    run_load(32'h0000_0040, 3'b010, 32'hDEAD_BEEF, TIMEOUT + 4);
    run_load(32'h0000_0080, 3'b010, 32'hCAFE_F00D, TIMEOUT);
    run_load(32'h0000_0081, 3'b100, 32'h00C3_0000, 1);

    // Reset during the second REQ cycle
    ld_req    = 1'b1;
    ld_addr   = 32'h0000_0100;
    ld_funct3 = 3'b010;
    @(posedge clk);
    #1;
    ld_req = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("midreset_mem_req", 32'(mem_req), 32'd0);
    check("midreset_stall", 32'(stall), 32'd0);
    check("midreset_rd_mem", rd_mem, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    model_rd  = '0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check("late_ack_mem_req", 32'(mem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("late_ack_rd_mem", rd_mem, 32'd0);
    run_load(32'h0000_0104, 3'b010, 32'h1234_5678, 2);

    // Random loads
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a;
      logic [2:0]  f;
      a = $urandom;
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        if (f == 3'd2) a = a & ~32'h3;
        else if (f == 3'd1 || f == 3'd5) a = a & ~32'h1;
      end
      run_load(a, f, $urandom, int'($urandom_range(1, TIMEOUT + 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    check("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
